// File: rtl/position_step_controller_pkg.sv
// Shared constants for the position step controller: direction codes, default
// playfield window and FSM state encoding.
package position_step_controller_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_HOLD  = 2'b10;

  localparam int DEF_MIN_POS    = 15;
  localparam int DEF_MAX_POS    = 624;
  localparam int DEF_CENTER_POS = 320;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_WAIT = 2'd1,
    ST_REPEAT    = 2'd2,
    ST_LOCK      = 2'd3
  } state_t;

endpackage

// File: rtl/position_step_controller_btn.sv
// Two-flop synchronizer for one asynchronous active-low button; both flops
// reset to 1 so the button reads as released out of reset.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/position_step_controller.sv
// Position counter driven by two active-low buttons: immediate step on press,
// auto-repeat after a hold delay on a free-running tick, clamped, with recentre.
module position_step_controller
  import position_step_controller_pkg::*;
#(
  parameter int MIN_POS      = DEF_MIN_POS,
  parameter int MAX_POS      = DEF_MAX_POS,
  parameter int CENTER_POS   = DEF_CENTER_POS,
  parameter int TICK_DIV     = 100000,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pbL,
  input  logic       pbR,
  input  logic       center_req,
  output logic [9:0] pos,
  output logic [1:0] dir,
  output logic       step,
  output logic       at_min,
  output logic       at_max
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = 16;
  localparam logic [9:0] MIN_P = 10'(MIN_POS);
  localparam logic [9:0] MAX_P = 10'(MAX_POS);
  localparam logic [9:0] CTR_P = 10'(CENTER_POS);

  logic sync_l, sync_r;

  btn_sync u_sync_l (.clk(clk), .reset(reset), .din(pbL), .dout(sync_l));
  btn_sync u_sync_r (.clk(clk), .reset(reset), .din(pbR), .dout(sync_r));

  logic req_l, req_r, released;
  assign req_l    = ~sync_l & sync_r;
  assign req_r    = sync_l & ~sync_r;
  assign released = sync_l & sync_r;

  // Prescaler free-runs; button activity never realigns it.
  logic [PW-1:0] pcnt;
  logic          tick;
  assign tick = (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) pcnt <= '0;
    else       pcnt <= tick ? '0 : pcnt + PW'(1);
  end

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          latch_r, latch_r_nxt;
  logic          same_req, hold_done, rpt_done;

  assign same_req  = latch_r ? req_r : req_l;
  assign hold_done = tick && (tcnt == TW'(HOLD_TICKS - 1));
  assign rpt_done  = tick && (tcnt == TW'(REPEAT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tcnt    <= '0;
      latch_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      tcnt    <= tcnt_nxt;
      latch_r <= latch_r_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    latch_r_nxt = latch_r;
    case (state)
      ST_IDLE: begin
        if (req_l || req_r) begin
          state_nxt   = ST_HOLD_WAIT;
          tcnt_nxt    = '0;
          latch_r_nxt = req_r;
        end
      end
      ST_HOLD_WAIT: begin
        if (!same_req) begin
          state_nxt = ST_IDLE;
          tcnt_nxt  = '0;
        end else if (hold_done) begin
          state_nxt = ST_REPEAT;
          tcnt_nxt  = '0;
        end else if (tick) begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      ST_REPEAT: begin
        if (!same_req) begin
          state_nxt = ST_IDLE;
          tcnt_nxt  = '0;
        end else if (rpt_done) begin
          tcnt_nxt = '0;
        end else if (tick) begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      ST_LOCK: begin
        if (released) begin
          state_nxt = ST_IDLE;
          tcnt_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (center_req) begin
      state_nxt = ST_LOCK;
      tcnt_nxt  = '0;
    end
  end

  logic want_step, step_right;

  always_comb begin
    want_step  = 1'b0;
    step_right = latch_r;
    case (state)
      ST_IDLE: begin
        want_step  = req_l | req_r;
        step_right = req_r;
      end
      ST_HOLD_WAIT: want_step = same_req & hold_done;
      ST_REPEAT:    want_step = same_req & rpt_done;
      default:      want_step = 1'b0;
    endcase
    dir = DIR_HOLD;
    if (state == ST_HOLD_WAIT || state == ST_REPEAT) begin
      if (!latch_r && pos > MIN_P)     dir = DIR_LEFT;
      else if (latch_r && pos < MAX_P) dir = DIR_RIGHT;
    end
  end

  // A step blocked by the window is dropped silently; the FSM still advances.
  logic can_move;
  assign can_move = step_right ? (pos < MAX_P) : (pos > MIN_P);

  always_ff @(posedge clk) begin
    if (reset) begin
      pos  <= CTR_P;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
      if (center_req) begin
        pos <= CTR_P;
      end else if (want_step && can_move) begin
        pos  <= step_right ? pos + 10'd1 : pos - 10'd1;
        step <= 1'b1;
      end
    end
  end

  assign at_min = (pos == MIN_P);
  assign at_max = (pos == MAX_P);

endmodule

// File: tb/tb_position_step_controller.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs, which are
// queued at drive time and compared after the edge, plus directed scenario checks.
module tb_position_step_controller;

  localparam int TDIV = 4;
  localparam int HOLD = 3;
  localparam int RPT  = 2;
  localparam int PMIN = 15;
  localparam int PMAX = 624;
  localparam int PCTR = 320;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pbL = 1'b1;
  logic       pbR = 1'b1;
  logic       center_req = 1'b0;
  logic [9:0] pos;
  logic [1:0] dir;
  logic       step;
  logic       at_min;
  logic       at_max;

  always #5 clk = ~clk;

  position_step_controller #(
    .MIN_POS(PMIN), .MAX_POS(PMAX), .CENTER_POS(PCTR),
    .TICK_DIV(TDIV), .HOLD_TICKS(HOLD), .REPEAT_TICKS(RPT)
  ) dut (
    .clk(clk), .reset(reset), .pbL(pbL), .pbR(pbR), .center_req(center_req),
    .pos(pos), .dir(dir), .step(step), .at_min(at_min), .at_max(at_max)
  );

  typedef struct {
    int pos;
    int step;
    int dir;
    int amin;
    int amax;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int step_seen = 0;

  // Model state: sync flops, prescaler, FSM (0 idle, 1 hold-wait, 2 repeat, 3 lock).
  int m_s1l, m_s2l, m_s1r, m_s2r, m_cnt, m_st, m_tcnt, m_right, m_pos, m_step;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int rq;
    bit tk;
    bit go;
    if (reset) begin
      m_s1l = 1; m_s2l = 1; m_s1r = 1; m_s2r = 1;
      m_cnt = 0; m_st = 0; m_tcnt = 0; m_right = 0; m_pos = PCTR; m_step = 0;
      return;
    end
    rq = (m_s2l == 0 && m_s2r == 1) ? 1 : (m_s2l == 1 && m_s2r == 0) ? 2 : 0;
    tk = (m_cnt == TDIV - 1);
    go = 0;
    case (m_st)
      0: if (rq != 0) begin
        go = 1; m_right = (rq == 2); m_st = 1; m_tcnt = 0;
      end
      1, 2: begin
        if (rq != (m_right ? 2 : 1)) begin
          m_st = 0; m_tcnt = 0;
        end else if (tk) begin
          m_tcnt++;
          if (m_st == 1 && m_tcnt == HOLD) begin
            go = 1; m_st = 2; m_tcnt = 0;
          end else if (m_st == 2 && m_tcnt == RPT) begin
            go = 1; m_tcnt = 0;
          end
        end
      end
      default: if (m_s2l == 1 && m_s2r == 1) begin
        m_st = 0; m_tcnt = 0;
      end
    endcase
    m_step = 0;
    if (center_req) begin
      m_pos = PCTR; m_st = 3; m_tcnt = 0;
    end else if (go) begin
      if (m_right && m_pos < PMAX) begin
        m_pos++; m_step = 1;
      end else if (!m_right && m_pos > PMIN) begin
        m_pos--; m_step = 1;
      end
    end
    m_cnt = tk ? 0 : m_cnt + 1;
    m_s2l = m_s1l; m_s1l = int'(pbL);
    m_s2r = m_s1r; m_s1r = int'(pbR);
  endtask

  function automatic int model_dir();
    if (m_st == 1 || m_st == 2) begin
      if (!m_right && m_pos > PMIN) return 0;
      if (m_right && m_pos < PMAX) return 1;
    end
    return 2;
  endfunction

  task automatic cycle();
    exp_t e;
    exp_t g;
    model_edge();
    e.pos = m_pos; e.step = m_step; e.dir = model_dir();
    e.amin = (m_pos == PMIN) ? 1 : 0; e.amax = (m_pos == PMAX) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check_val("pos", 32'(pos), g.pos);
    check_val("step", 32'(step), g.step);
    check_val("dir", 32'(dir), g.dir);
    check_val("at_min", 32'(at_min), g.amin);
    check_val("at_max", 32'(at_max), g.amax);
    if (step === 1'b1) step_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic recentre();
    center_req = 1'b1;
    cycle();
    center_req = 1'b0;
    run(4);
  endtask

  task automatic hold_until(input string tag, input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (pos == 10'(target)) break;
    end
    check_val(tag, 32'(pos), target);
  endtask

  initial begin
    // Reset
    run(2);
    check_val("rst_pos", 32'(pos), PCTR);
    check_val("rst_dir", 32'(dir), 2);
    check_val("rst_step", 32'(step), 0);
    check_val("rst_amin", 32'(at_min), 0);
    check_val("rst_amax", 32'(at_max), 0);
    reset = 1'b0;
    run(3);

    // Single tap right
    step_seen = 0;
    pbR = 1'b0;
    run(3);
    check_val("tap_pos_k2", 32'(pos), 321);
    check_val("tap_step_k2", 32'(step), 1);
    pbR = 1'b1;
    run(10);
    check_val("tap_steps", step_seen, 1);
    check_val("tap_dir_end", 32'(dir), 2);

    // Hold auto-repeat left
    recentre();
    pbL = 1'b0;
    run(3);
    check_val("hold_first", 32'(pos), 319);
    run(37);
    pbL = 1'b1;
    run(6);

    // Clamp at the right limit
    recentre();
    pbR = 1'b0;
    hold_until("clamp_623", 623, 4000);
    hold_until("clamp_624", 624, 20);
    step_seen = 0;
    run(30);
    check_val("clamp_steps", step_seen, 0);
    check_val("clamp_pos", 32'(pos), PMAX);
    check_val("clamp_atmax", 32'(at_max), 1);
    check_val("clamp_dir", 32'(dir), 2);
    pbR = 1'b1;
    run(6);

    // Both pressed
    recentre();
    pbL = 1'b0;
    run(15);
    pbR = 1'b0;
    run(3);
    step_seen = 0;
    run(20);
    check_val("both_steps", step_seen, 0);
    check_val("both_dir", 32'(dir), 2);
    pbR = 1'b1;
    run(3);
    check_val("both_restart", step_seen, 1);

    // Recentre during REPEAT with pbL held
    run(25);
    center_req = 1'b1;
    cycle();
    center_req = 1'b0;
    check_val("ctr_pos", 32'(pos), PCTR);
    check_val("ctr_step", 32'(step), 0);
    step_seen = 0;
    run(30);
    check_val("ctr_lock_steps", step_seen, 0);
    check_val("ctr_lock_pos", 32'(pos), PCTR);
    pbL = 1'b1;
    run(4);
    pbL = 1'b0;
    run(3);
    check_val("ctr_repress", 32'(pos), 319);

    // Reset during REPEAT
    run(25);
    reset = 1'b1;
    cycle();
    check_val("mid_rst_pos", 32'(pos), PCTR);
    check_val("mid_rst_dir", 32'(dir), 2);
    check_val("mid_rst_step", 32'(step), 0);
    check_val("mid_rst_amin", 32'(at_min), 0);
    check_val("mid_rst_amax", 32'(at_max), 0);
    reset = 1'b0;
    pbL = 1'b1;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
